// File: rtl/search_arbiter_pkg.sv
// Shared constants and types for the arbitrated binary-search block.
package bs_pkg;

    localparam int unsigned N    = 24;
    localparam int unsigned W    = 32;
    localparam int unsigned NREQ = 4;
    localparam int unsigned IW   = 6;

    localparam logic signed [IW-1:0] NOT_FOUND = '1;

    typedef enum logic [1:0] {
        StIdle,
        StSearch,
        StResp
    } state_e;

endpackage

// File: rtl/search_arbiter_if.sv
// Requester/table bus between the search arbiter and its clients.
interface search_arbiter_if #(
    parameter int unsigned N    = bs_pkg::N,
    parameter int unsigned W    = bs_pkg::W,
    parameter int unsigned NREQ = bs_pkg::NREQ,
    parameter int unsigned IW   = bs_pkg::IW
);
    localparam int unsigned AW = $clog2(N);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ*W-1:0]      req_key;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        rsp_valid;
    logic                   rsp_found;
    logic signed [IW-1:0]   rsp_index;
    logic                   tbl_we;
    logic [AW-1:0]          tbl_addr;
    logic signed [W-1:0]    tbl_wdata;
    logic                   busy;

    modport master (
        output req_valid, req_key, tbl_we, tbl_addr, tbl_wdata,
        input  req_ready, rsp_valid, rsp_found, rsp_index, busy
    );

    modport slave (
        input  req_valid, req_key, tbl_we, tbl_addr, tbl_wdata,
        output req_ready, rsp_valid, rsp_found, rsp_index, busy
    );

endinterface

// File: rtl/bsearch_core.sv
// Sorted table plus iterative one-compare-per-cycle binary search.
module bsearch_core #(
    parameter int unsigned N  = bs_pkg::N,
    parameter int unsigned W  = bs_pkg::W,
    parameter int unsigned IW = bs_pkg::IW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic signed [W-1:0]     i_key,
    input  logic                    i_we,
    input  logic [$clog2(N)-1:0]    i_addr,
    input  logic signed [W-1:0]     i_wdata,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_found,
    output logic signed [IW-1:0]    o_index
);
    import bs_pkg::*;

    localparam int unsigned AW = $clog2(N);
    localparam logic signed [IW-1:0] NotFound = IW'(NOT_FOUND);

    logic signed [W-1:0]    r_mem [N];
    state_e                 r_state;
    state_e                 w_state_d;
    logic signed [W-1:0]    r_key;
    logic [AW-1:0]          r_f;
    logic [AW-1:0]          r_l;
    logic                   r_found;
    logic signed [IW-1:0]   r_index;

    logic [AW:0]            w_sum;
    logic [AW-1:0]          w_m;
    logic signed [W-1:0]    w_mid;
    logic                   w_eq;
    logic                   w_lt;

    // Sum kept one bit wider so the midpoint never wraps.
    assign w_sum = {1'b0, r_f} + {1'b0, r_l};
    assign w_m   = AW'(w_sum >> 1);
    assign w_mid = r_mem[w_m];
    assign w_eq  = (r_key == w_mid);
    assign w_lt  = (r_key < w_mid);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_d = StSearch;
                end
            end
            StSearch: begin
                if (w_eq || (w_lt && (w_m == r_f)) || (!w_lt && (w_m == r_l))) begin
                    w_state_d = StResp;
                end
            end
            StResp:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        o_busy  = 1'b0;
        o_done  = 1'b0;
        o_found = 1'b0;
        o_index = NotFound;
        if (!rst) begin
            o_busy = (r_state != StIdle);
            if (r_state == StResp) begin
                o_done  = 1'b1;
                o_found = r_found;
                o_index = r_index;
            end
        end
    end

    // Bounds only move inward on a strict miss, so l=m-1 needs m>f and f=m+1 needs m<l.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_found <= 1'b0;
            r_index <= NotFound;
        end else if ((r_state == StIdle) && i_start) begin
            r_key   <= i_key;
            r_f     <= '0;
            r_l     <= AW'(N - 1);
            r_found <= 1'b0;
            r_index <= NotFound;
        end else if (r_state == StSearch) begin
            if (w_eq) begin
                r_found <= 1'b1;
                r_index <= IW'(w_m);
            end else if (w_lt) begin
                if (w_m == r_f) begin
                    r_found <= 1'b0;
                    r_index <= NotFound;
                end else begin
                    r_l <= w_m - AW'(1);
                end
            end else begin
                if (w_m == r_l) begin
                    r_found <= 1'b0;
                    r_index <= NotFound;
                end else begin
                    r_f <= w_m + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_we && !o_busy && (32'(i_addr) < N)) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/search_arbiter.sv
// Round-robin front end sharing one binary-search core between requesters.
module search_arbiter #(
    parameter int unsigned N    = bs_pkg::N,
    parameter int unsigned W    = bs_pkg::W,
    parameter int unsigned NREQ = bs_pkg::NREQ,
    parameter int unsigned IW   = bs_pkg::IW
) (
    input  logic            clk,
    input  logic            rst,
    search_arbiter_if.slave io_bus
);
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]          r_ptr;
    logic [PW-1:0]          r_owner;
    logic [PW-1:0]          w_winner;
    logic [PW-1:0]          w_ptr_d;
    logic                   w_any;
    logic                   w_grant;
    logic                   w_busy;
    logic                   w_done;
    logic                   w_found;
    logic signed [IW-1:0]   w_index;
    logic signed [W-1:0]    w_key;

    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int unsigned k);
        return PW'((32'(base) + k) % NREQ);
    endfunction

    // Scan from the farthest offset down so the nearest valid requester wins.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            if (io_bus.req_valid[rr_idx(r_ptr, unsigned'(k))]) begin
                w_any    = 1'b1;
                w_winner = rr_idx(r_ptr, unsigned'(k));
            end
        end
    end

    assign w_grant = w_any && !w_busy && !rst;
    assign w_key   = io_bus.req_key[32'(w_winner) * W +: W];
    assign w_ptr_d = (w_winner == PW'(NREQ - 1)) ? '0 : w_winner + PW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= '0;
            r_owner <= '0;
        end else if (w_grant) begin
            r_ptr   <= w_ptr_d;
            r_owner <= w_winner;
        end
    end

    assign io_bus.req_ready = w_grant ? (NREQ'(1) << w_winner) : '0;
    assign io_bus.rsp_valid = w_done ? (NREQ'(1) << r_owner) : '0;
    assign io_bus.rsp_found = w_found;
    assign io_bus.rsp_index = w_index;
    assign io_bus.busy      = w_busy;

    bsearch_core #(
        .N  (N),
        .W  (W),
        .IW (IW)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_grant),
        .i_key   (w_key),
        .i_we    (io_bus.tbl_we),
        .i_addr  (io_bus.tbl_addr),
        .i_wdata (io_bus.tbl_wdata),
        .o_busy  (w_busy),
        .o_done  (w_done),
        .o_found (w_found),
        .o_index (w_index)
    );

endmodule

// File: tb/tb_search_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a table/RR model.
module tb_search_arbiter;
    import bs_pkg::*;

    localparam int unsigned AW = $clog2(N);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    search_arbiter_if #(.N(N), .W(W), .NREQ(NREQ), .IW(IW)) bus_if ();

    search_arbiter #(.N(N), .W(W), .NREQ(NREQ), .IW(IW)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus_if)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic signed [W-1:0] model_mem [N];
    int model_ptr = 0;

    function automatic int ref_index(input logic signed [W-1:0] key);
        for (int i = 0; i < int'(N); i++) begin
            if (model_mem[i] == key) return i;
        end
        return -1;
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] set, input int ptr);
        for (int k = 0; k < int'(NREQ); k++) begin
            if (set[(ptr + k) % int'(NREQ)]) return (ptr + k) % int'(NREQ);
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] oh(input int i);
        return NREQ'(1) << i;
    endfunction

    task automatic write_tbl(input int a, input logic signed [W-1:0] d);
        @(negedge clk);
        bus_if.tbl_we    = 1'b1;
        bus_if.tbl_addr  = AW'(a);
        bus_if.tbl_wdata = d;
        if (a < int'(N)) model_mem[a] = d;
        @(negedge clk);
        bus_if.tbl_we = 1'b0;
    endtask

    // Holds req_valid[r] until granted; returns at the negedge of the first SEARCH cycle.
    task automatic issue(input int r, input logic signed [W-1:0] key,
                         output logic [NREQ-1:0] rdy, output bit ok);
        ok  = 1'b0;
        rdy = '0;
        @(negedge clk);
        bus_if.req_valid[r]       = 1'b1;
        bus_if.req_key[r*W +: W]  = key;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (bus_if.req_ready != '0) begin
                rdy = bus_if.req_ready;
                ok  = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        bus_if.req_valid[r]      = 1'b0;
        bus_if.req_key[r*W +: W] = $urandom;
    endtask

    task automatic await_rsp(output logic [NREQ-1:0] v, output logic f,
                             output logic signed [IW-1:0] idx, output int cyc,
                             output int bad, output bit ok);
        v = '0; f = 1'b0; idx = '0; cyc = 0; bad = 0; ok = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            #1;
            if (bus_if.rsp_valid != '0) begin
                v = bus_if.rsp_valid; f = bus_if.rsp_found; idx = bus_if.rsp_index;
                cyc = c; ok = 1'b1;
                break;
            end
            if (bus_if.rsp_found !== 1'b0 || bus_if.rsp_index !== NOT_FOUND) bad++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.req_valid = '1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (bus_if.req_ready !== '0) begin n_fail++;
            $display("FAIL reset_ready: got %b want 0", bus_if.req_ready); end
        n_checks++; if (bus_if.rsp_valid !== '0) begin n_fail++;
            $display("FAIL reset_rsp_valid: got %b want 0", bus_if.rsp_valid); end
        n_checks++; if (bus_if.rsp_found !== 1'b0) begin n_fail++;
            $display("FAIL reset_found: got %b want 0", bus_if.rsp_found); end
        n_checks++; if (bus_if.rsp_index !== NOT_FOUND) begin n_fail++;
            $display("FAIL reset_index: got %h want %h", bus_if.rsp_index, NOT_FOUND); end
        n_checks++; if (bus_if.busy !== 1'b0) begin n_fail++;
            $display("FAIL reset_busy: got %b want 0", bus_if.busy); end
        bus_if.req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (bus_if.busy !== 1'b0 || bus_if.req_ready !== '0) begin n_fail++;
            $display("FAIL post_reset_idle: busy %b ready %b want 0/0", bus_if.busy,
                     bus_if.req_ready); end
    endtask

    task automatic test_basic();
        logic [NREQ-1:0] rdy, v;
        logic f;
        logic signed [IW-1:0] idx;
        int cyc, bad;
        bit ok;
        issue(0, 70, rdy, ok);
        n_checks++; if (!ok || rdy !== oh(0)) begin n_fail++;
            $display("FAIL basic_grant: got %b want %b", rdy, oh(0)); end
        #1;
        n_checks++; if (bus_if.busy !== 1'b1 || bus_if.req_ready !== '0) begin n_fail++;
            $display("FAIL basic_search_state: busy %b ready %b want 1/0", bus_if.busy,
                     bus_if.req_ready); end
        await_rsp(v, f, idx, cyc, bad, ok);
        n_checks++; if (!ok || cyc > 6) begin n_fail++;
            $display("FAIL basic_latency: got %0d cycles (ok=%0d) want <=6", cyc, ok); end
        n_checks++; if (v !== oh(0)) begin n_fail++;
            $display("FAIL basic_rsp_valid: got %b want %b", v, oh(0)); end
        n_checks++; if (f !== 1'b1 || idx !== 6'sd7) begin n_fail++;
            $display("FAIL basic_result: got found %b idx %0d want 1/7", f, idx); end
        n_checks++; if (bad !== 0) begin n_fail++;
            $display("FAIL basic_idle_outputs: got %0d bad cycles want 0", bad); end
        @(negedge clk);
        #1;
        n_checks++; if (bus_if.rsp_valid !== '0 || bus_if.busy !== 1'b0) begin n_fail++;
            $display("FAIL basic_after_resp: rsp_valid %b busy %b want 0/0",
                     bus_if.rsp_valid, bus_if.busy); end
    endtask

    task automatic test_boundaries();
        logic signed [W-1:0] keys [6];
        logic [NREQ-1:0] rdy, v;
        logic f;
        logic signed [IW-1:0] idx, eidx;
        int cyc, bad;
        bit ok;
        keys = '{75, -5, 231, 0, 230, 120};
        for (int t = 0; t < 6; t++) begin
            int r;
            r = t % int'(NREQ);
            eidx = IW'(ref_index(keys[t]));
            issue(r, keys[t], rdy, ok);
            await_rsp(v, f, idx, cyc, bad, ok);
            n_checks++; if (!ok || v !== oh(r)) begin n_fail++;
                $display("FAIL bound_rsp_valid key %0d: got %b want %b", keys[t], v, oh(r)); end
            n_checks++; if (f !== (ref_index(keys[t]) >= 0) || idx !== eidx) begin n_fail++;
                $display("FAIL bound_result key %0d: got %b/%0d want %b/%0d", keys[t], f, idx,
                         (ref_index(keys[t]) >= 0), eidx); end
        end
    endtask

    task automatic test_write_busy();
        logic [NREQ-1:0] rdy, v;
        logic f;
        logic signed [IW-1:0] idx;
        int cyc, bad;
        bit ok;
        issue(1, 70, rdy, ok);
        #1;
        n_checks++; if (bus_if.busy !== 1'b1) begin n_fail++;
            $display("FAIL wbusy_busy: got %b want 1", bus_if.busy); end
        bus_if.tbl_we = 1'b1; bus_if.tbl_addr = AW'(7); bus_if.tbl_wdata = 999;
        @(negedge clk);
        bus_if.tbl_we = 1'b0;
        await_rsp(v, f, idx, cyc, bad, ok);
        n_checks++; if (!ok || f !== 1'b1 || idx !== 6'sd7) begin n_fail++;
            $display("FAIL wbusy_during: got %b/%0d want 1/7", f, idx); end
        issue(2, 70, rdy, ok);
        await_rsp(v, f, idx, cyc, bad, ok);
        n_checks++; if (!ok || f !== 1'b1 || idx !== 6'sd7) begin n_fail++;
            $display("FAIL wbusy_after: got %b/%0d want 1/7", f, idx); end
        write_tbl(23, 240);
        write_tbl(24, 5);
        issue(3, 240, rdy, ok);
        await_rsp(v, f, idx, cyc, bad, ok);
        n_checks++; if (!ok || f !== 1'b1 || idx !== 6'sd23) begin n_fail++;
            $display("FAIL idle_write: got %b/%0d want 1/23", f, idx); end
        write_tbl(23, 230);
        issue(0, 240, rdy, ok);
        await_rsp(v, f, idx, cyc, bad, ok);
        n_checks++; if (!ok || f !== 1'b0 || idx !== NOT_FOUND) begin n_fail++;
            $display("FAIL idle_restore: got %b/%0d want 0/-1", f, idx); end
    endtask

    task automatic test_rst_mid_search();
        logic [NREQ-1:0] rdy, v;
        logic f;
        logic signed [IW-1:0] idx;
        int cyc, bad, seen;
        bit ok;
        issue(2, 70, rdy, ok);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (bus_if.busy !== 1'b0) begin n_fail++;
            $display("FAIL rst_busy_during: got %b want 0", bus_if.busy); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (bus_if.busy !== 1'b0) begin n_fail++;
            $display("FAIL rst_busy_after: got %b want 0", bus_if.busy); end
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (bus_if.rsp_valid !== '0) seen++;
            @(negedge clk);
        end
        n_checks++; if (seen !== 0) begin n_fail++;
            $display("FAIL rst_abort: got %0d rsp cycles want 0", seen); end
        issue(3, 120, rdy, ok);
        await_rsp(v, f, idx, cyc, bad, ok);
        n_checks++; if (!ok || v !== oh(3) || f !== 1'b1 || idx !== 6'sd12) begin n_fail++;
            $display("FAIL rst_recover: got %b %b/%0d want %b 1/12", v, f, idx, oh(3)); end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] rdy, v;
        logic f;
        logic signed [IW-1:0] idx;
        int cyc, bad;
        bit ok, got;
        int exp_order [6];
        exp_order = '{0, 1, 2, 3, 0, 2};
        issue(1, 10, rdy, ok);
        await_rsp(v, f, idx, cyc, bad, ok);
        @(negedge clk);
        rst = 1'b1;
        bus_if.req_valid = '1;
        for (int r = 0; r < int'(NREQ); r++) bus_if.req_key[r*W +: W] = 10 * r;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (bus_if.req_ready !== '0) begin n_fail++;
            $display("FAIL rr_ready_in_reset: got %b want 0", bus_if.req_ready); end
        @(negedge clk);
        rst = 1'b0;
        for (int g = 0; g < 6; g++) begin
            got = 1'b0;
            rdy = '0;
            for (int c = 0; c < 30; c++) begin
                #1;
                if (bus_if.req_ready != '0) begin rdy = bus_if.req_ready; got = 1'b1; break; end
                @(negedge clk);
            end
            n_checks++; if (!got || rdy !== oh(exp_order[g])) begin n_fail++;
                $display("FAIL rr_grant_%0d: got %b want %b", g, rdy, oh(exp_order[g])); end
            @(negedge clk);
            bus_if.req_valid = bus_if.req_valid & ~rdy & ~oh(exp_order[g]);
            if (g == 3) bus_if.req_valid = bus_if.req_valid | oh(0) | oh(2);
        end
        bus_if.req_valid = '0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_random();
        logic [NREQ-1:0] set, pending, rdy, v;
        logic signed [W-1:0] rkey [NREQ];
        logic signed [W-1:0] ekey;
        logic f;
        logic signed [IW-1:0] idx;
        int cyc, bad, e, lo, span, base;
        bit ok, got;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_ptr = 0;
        for (int it = 0; it < 40; it++) begin
            if (it > 0 && it % 10 == 0) begin
                base = int'($urandom_range(0, 200)) - 100;
                for (int i = 0; i < int'(N); i++) begin
                    base = base + int'($urandom_range(1, 20));
                    write_tbl(i, W'(base));
                end
            end
            set = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            lo = int'(model_mem[0]) - 10;
            span = int'(model_mem[N-1]) - lo + 10;
            for (int r = 0; r < int'(NREQ); r++) begin
                if ($urandom_range(0, 1) == 1) rkey[r] = model_mem[$urandom_range(0, N - 1)];
                else rkey[r] = W'(lo + int'($urandom_range(0, span)));
            end
            @(negedge clk);
            bus_if.req_valid = set;
            for (int r = 0; r < int'(NREQ); r++) bus_if.req_key[r*W +: W] = rkey[r];
            pending = set;
            while (pending != '0) begin
                got = 1'b0;
                rdy = '0;
                for (int c = 0; c < 30; c++) begin
                    #1;
                    if (bus_if.req_ready != '0) begin rdy = bus_if.req_ready; got = 1'b1; break; end
                    @(negedge clk);
                end
                if (!got) begin
                    n_checks++; n_fail++;
                    $display("FAIL rand_grant_timeout it %0d: pending %b", it, pending);
                    break;
                end
                e = rr_pick(pending, model_ptr);
                ekey = rkey[e];
                n_checks++; if (rdy !== oh(e)) begin n_fail++;
                    $display("FAIL rand_grant it %0d: got %b want %b", it, rdy, oh(e)); end
                model_ptr = (e + 1) % int'(NREQ);
                pending = pending & ~oh(e) & ~rdy;
                @(negedge clk);
                bus_if.req_valid = bus_if.req_valid & ~oh(e) & ~rdy;
                bus_if.req_key[e*W +: W] = $urandom;
                await_rsp(v, f, idx, cyc, bad, ok);
                n_checks++; if (!ok || v !== oh(e)) begin n_fail++;
                    $display("FAIL rand_rsp_valid it %0d: got %b want %b", it, v, oh(e)); end
                n_checks++;
                if (f !== (ref_index(ekey) >= 0) || idx !== IW'(ref_index(ekey))) begin
                    n_fail++;
                    $display("FAIL rand_result it %0d key %0d: got %b/%0d want %b/%0d", it, ekey,
                             f, idx, (ref_index(ekey) >= 0), ref_index(ekey));
                end
            end
            bus_if.req_valid = '0;
        end
    endtask

    initial begin
        bus_if.req_valid = '0;
        bus_if.req_key   = '0;
        bus_if.tbl_we    = 1'b0;
        bus_if.tbl_addr  = '0;
        bus_if.tbl_wdata = '0;
        test_reset();
        for (int i = 0; i < int'(N); i++) write_tbl(i, W'(10 * i));
        test_basic();
        test_boundaries();
        test_write_busy();
        test_rst_mid_search();
        test_round_robin();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
